// File: rtl/fir_host_ctrl.sv
// fir_host_ctrl
// Initiator-side sequencer for a command-driven FIR core. It collects one
// frame of SIGNAL_LENGTH samples from an input stream, clears the core,
// writes the samples, starts computation, waits for done, then reads each
// result back and presents it on an output stream.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input sample stream (in_data, 32 bit)
//   out_valid/out_ready   output sample stream (out_data, out_last)
//   busy                  high whenever not IDLE
//   frame_done            one-cycle pulse after the last output handshake
//   err                   sticky compute-timeout flag, cleared on next frame
//   f_reset, f_operation, f_addr, f_x   command port to the FIR core
//   f_y, f_done                         read data / completion from the core
//
// Registered command outputs lag the state that issues them by one cycle:
// a command decided in state S is visible on the core port during the
// following cycle. The only exception is f_reset for CLEAR, which is raised
// on the IDLE->CLEAR transition so it is visible while CLEAR is current.
module fir_host_ctrl #(
  parameter int unsigned SIGNAL_LENGTH   = 1000,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned COMPUTE_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic        f_reset,
  output logic [1:0]  f_operation,
  output logic [31:0] f_addr,
  output logic [31:0] f_x,
  input  logic [31:0] f_y,
  input  logic        f_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_COMPUTE   = 3'd3;
  localparam logic [2:0] S_READ_REQ  = 3'd4;
  localparam logic [2:0] S_READ_WAIT = 3'd5;
  localparam logic [2:0] S_OUT       = 3'd6;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_COMPUTE = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  localparam logic [31:0] LAST_IDX = 32'(SIGNAL_LENGTH - 1);
  // Only meaningful when COMPUTE_TIMEOUT != 0.
  localparam logic [31:0] TMO_LAST = 32'(COMPUTE_TIMEOUT - 1);
  localparam logic [31:0] RD_LAT   = 32'(READ_LATENCY);

  logic [2:0]  state;
  logic [31:0] load_cnt;
  logic [31:0] rd_cnt;
  logic [31:0] comp_cnt;
  logic [31:0] wait_cnt;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      f_reset     <= 1'b1;
      f_operation <= OP_NOP;
      f_addr      <= '0;
      f_x         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      load_cnt    <= '0;
      rd_cnt      <= '0;
      comp_cnt    <= '0;
      wait_cnt    <= '0;
    end else begin
      // Pulses and commands default to idle; states below override.
      f_reset     <= 1'b0;
      f_operation <= OP_NOP;
      frame_done  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state   <= S_CLEAR;
            err     <= 1'b0;
            f_reset <= 1'b1;
          end
        end

        S_CLEAR: begin
          state    <= S_LOAD;
          load_cnt <= '0;
        end

        S_LOAD: begin
          if (in_valid) begin
            f_operation <= OP_WRITE;
            f_addr      <= load_cnt;
            f_x         <= in_data;
            load_cnt    <= load_cnt + 32'd1;
            if (load_cnt == LAST_IDX) begin
              state    <= S_COMPUTE;
              comp_cnt <= '0;
            end
          end
        end

        // The first COMPUTE cycle still shows the final write on the port;
        // compute commands follow from the second cycle on.
        S_COMPUTE: begin
          if (f_done) begin
            state  <= S_READ_REQ;
            rd_cnt <= '0;
          end else if ((COMPUTE_TIMEOUT != 0) && (comp_cnt == TMO_LAST)) begin
            err     <= 1'b1;
            f_reset <= 1'b1;
            state   <= S_IDLE;
          end else begin
            comp_cnt    <= comp_cnt + 32'd1;
            f_operation <= OP_COMPUTE;
            f_addr      <= '0;
          end
        end

        S_READ_REQ: begin
          f_operation <= OP_READ;
          f_addr      <= rd_cnt;
          wait_cnt    <= '0;
          state       <= S_READ_WAIT;
        end

        // wait_cnt==0 is the cycle the read is visible on the port, so the
        // word is on f_y when wait_cnt reaches READ_LATENCY.
        S_READ_WAIT: begin
          if (wait_cnt == RD_LAT) begin
            out_data  <= f_y;
            out_valid <= 1'b1;
            out_last  <= (rd_cnt == LAST_IDX);
            state     <= S_OUT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              rd_cnt <= rd_cnt + 32'd1;
              state  <= S_READ_REQ;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
